cache_request_sequencer: RTL and testbench
==========================================

// Module: cache_request_sequencer
// PURPOSE
// Front end that drives the set-associative LRU cache model one access at a time. It accepts 32-bit
//   trace addresses over a valid/ready handshake and buffers them in a small FIFO. It splits each address
//   into tag/index/block_offset, pulses find_start, and holds the fields stable until the cache's
//   updated pulse has completed. It also counts issued accesses and hits, and flags a stalled cache.
// PARAMETERS
// way             4          associativity; must match the downstream cache
// block_size_byte 16         line size in bytes (power of 2)
// cache_size_byte 32*1024    total capacity in bytes (power of 2)
// FIFO_DEPTH      8          address buffer entries (power of 2, >=2)
// TIMEOUT_CYC     64         max cycles from find_start to updated before timeout_err is raised
// Derived widths:
//   off_w = log2(block_size_byte)
//   set_w = log2(cache_size_byte/(block_size_byte*way))
//   tag_w = 32-set_w-off_w
// PORTS
// clk            in   1      rising-edge clock
// rst            in   1      asynchronous, active-high reset
// addr_in        in   32     trace address
// addr_valid     in   1      addr_in valid
// addr_last      in   1      qualifies addr_in as final trace entry
// addr_ready     out  1      FIFO not full
// tag            out  tag_w  tag field to cache
// index          out  set_w  set index to cache
// block_offset   out  off_w  offset to cache
// find_start     out  1      one-cycle lookup request
// updated        in   1      cache one-cycle completion pulse
// found_in_cache in   1      cache hit flag, valid while updated=1
// access_count   out  20     accesses completed
// hit_count      out  20     completed accesses with found_in_cache=1 at updated
// busy           out  1      FSM not IDLE or FIFO not empty
// trace_done     out  1      sticky: last entry completed
// timeout_err    out  1      sticky: updated not seen within TIMEOUT_CYC
// BEHAVIOUR
// - Reset (async, any state): all outputs 0, FIFO emptied, FSM=IDLE, counters 0. Reset mid-access abandons it; no count.
// - Handshake: an entry is pushed when addr_valid & addr_ready.
//   - addr_ready = !full, with no same-cycle pop bypass.
//   - Push and pop in the same cycle keep the occupancy unchanged.
//   - Pointers wrap modulo FIFO_DEPTH. addr_last is stored with each entry.
// - Field split, registered on pop and held until the next pop:
//   - block_offset = addr[off_w-1:0]
//   - index = addr[off_w+set_w-1:off_w]
//   - tag = addr[31:off_w+set_w]
// - FSM:
//   - IDLE: FIFO non-empty -> pop, latch fields, go ISSUE. Empty -> stay IDLE.
//   - ISSUE: find_start=1 for exactly this cycle -> WAIT. The fields are already stable this cycle.
//   - WAIT: on updated=1, access_count+1 and hit_count+=found_in_cache. If the entry is last, set trace_done.
//     Then go DRAIN.
//   - DRAIN: wait until updated=0, then go IDLE. This guarantees the cache has returned to idle before the
//     next find_start, so the minimum spacing between find_start pulses is 4 cycles.
// - Timeout: a counter runs in WAIT. When it reaches TIMEOUT_CYC, set timeout_err, count nothing, and go IDLE.
//   The FIFO is not flushed.
// - Counters saturate at 20'hFFFFF.
// - trace_done clears only on reset. Entries accepted after the last one are still processed.
// - find_start is never asserted outside ISSUE. updated seen in IDLE or ISSUE is ignored.
// TESTING
// 1. Push addr 0x0001_2345 (defaults) -> tag=0x9, index=0x034, block_offset=0x5; find_start one cycle after pop.
// 2. Stub cache asserts updated 3 cycles after find_start with found=1 -> access_count=1, hit_count=1;
//    next find_start no earlier than 2 cycles after updated falls.
// 3. Push 9 addrs back-to-back with the stub stalled -> addr_ready low after 8 pushes; all 9 issued in order.
// 4. Stub never answers -> timeout_err=1 on the 64th WAIT cycle; counts stay 0; the next entry is issued.
// 5. Assert rst in WAIT -> all outputs 0 immediately; the same access is not counted after release.
// 6. 3 addrs, the third with addr_last, hit/miss/hit -> access_count=3, hit_count=2, trace_done=1, busy=0.

Source files
------------

// File: rtl/cache_request_sequencer.sv
// cache_request_sequencer
//   Front end for a set-associative LRU cache model. Trace addresses arrive
//   over a valid/ready handshake and are buffered in a small FIFO. Entries
//   are issued to the cache one at a time. For each entry the address is
//   split into tag/index/block_offset and find_start is pulsed. The fields
//   stay stable until the cache's updated pulse has completed. The block
//   also counts completed accesses and hits, flags the final trace entry,
//   and flags a cache that never answers.
//
// Ports
//   clk_i             rising-edge clock
//   rst_i             asynchronous, active-high reset
//   addr_in_i         32-bit trace address
//   addr_valid_i      addr_in_i valid
//   addr_last_i       marks addr_in_i as the final trace entry
//   addr_ready_o      FIFO not full
//   tag_o             tag field to cache
//   index_o           set index to cache
//   block_offset_o    byte offset within the line
//   find_start_o      one-cycle lookup request
//   updated_i         cache one-cycle completion pulse
//   found_in_cache_i  cache hit flag, valid while updated_i=1
//   access_count_o    completed accesses (saturating)
//   hit_count_o       completed accesses that hit (saturating)
//   busy_o            FSM not idle or FIFO not empty
//   trace_done_o      sticky: last entry completed
//   timeout_err_o     sticky: cache did not answer in time
//
// States
//   IDLE  | wait for a buffered entry; pop it and latch its fields
//   ISSUE | find_start high for this single cycle
//   WAIT  | wait for updated, count the access; time out if it never comes
//   DRAIN | wait for updated to fall before returning to IDLE
module cache_request_sequencer #(
  parameter int WAY             = 4,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int CACHE_SIZE_BYTE = 32*1024,
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMEOUT_CYC     = 64,
  localparam int OFF_W = $clog2(BLOCK_SIZE_BYTE),
  localparam int SET_W = $clog2(CACHE_SIZE_BYTE/(BLOCK_SIZE_BYTE*WAY)),
  localparam int TAG_W = 32-SET_W-OFF_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      addr_in_i,
  input  logic             addr_valid_i,
  input  logic             addr_last_i,
  output logic             addr_ready_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [SET_W-1:0] index_o,
  output logic [OFF_W-1:0] block_offset_o,
  output logic             find_start_o,
  input  logic             updated_i,
  input  logic             found_in_cache_i,
  output logic [19:0]      access_count_o,
  output logic [19:0]      hit_count_o,
  output logic             busy_o,
  output logic             trace_done_o,
  output logic             timeout_err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state_q;

  // FIFO: entry bit 32 carries addr_last
  logic [32:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             addr_ready_q;
  logic             push;
  logic             pop;
  logic [32:0]      head;

  logic [TAG_W-1:0] tag_q;
  logic [SET_W-1:0] index_q;
  logic [OFF_W-1:0] offset_q;
  logic             last_q;
  logic             find_start_q;
  logic [TMR_W-1:0] timer_q;
  logic [19:0]      access_q;
  logic [19:0]      hit_q;
  logic             trace_done_q;
  logic             timeout_err_q;

  // addr_ready_q only gates the push; a pop in the same cycle does not
  // open a slot for a full FIFO.
  assign push = addr_valid_i & addr_ready_q;
  assign pop  = (state_q == ST_IDLE) && (count_q != '0);
  assign head = fifo_mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {addr_last_i, addr_in_i};
    end
  end

  // Ready is registered from the next occupancy so it reads 0 in reset
  // and otherwise always equals "not full" for the current cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      addr_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q      <= count_d;
      addr_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      tag_q         <= '0;
      index_q       <= '0;
      offset_q      <= '0;
      last_q        <= 1'b0;
      find_start_q  <= 1'b0;
      timer_q       <= '0;
      access_q      <= '0;
      hit_q         <= '0;
      trace_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            tag_q        <= head[31:OFF_W+SET_W];
            index_q      <= head[OFF_W+SET_W-1:OFF_W];
            offset_q     <= head[OFF_W-1:0];
            last_q       <= head[32];
            find_start_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          find_start_q <= 1'b0;
          timer_q      <= TMR_W'(TIMEOUT_CYC - 1);
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion in the final allowed cycle still counts.
          if (updated_i) begin
            if (access_q != '1) access_q <= access_q + 20'd1;
            if (found_in_cache_i && (hit_q != '1)) hit_q <= hit_q + 20'd1;
            if (last_q) trace_done_q <= 1'b1;
            state_q <= ST_DRAIN;
          end else if (timer_q == '0) begin
            timeout_err_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (!updated_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign addr_ready_o   = addr_ready_q;
  assign tag_o          = tag_q;
  assign index_o        = index_q;
  assign block_offset_o = offset_q;
  assign find_start_o   = find_start_q;
  assign access_count_o = access_q;
  assign hit_count_o    = hit_q;
  assign busy_o         = (state_q != ST_IDLE) || (count_q != '0);
  assign trace_done_o   = trace_done_q;
  assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_cache_request_sequencer.sv
module tb_cache_request_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_in_i;
  logic        addr_valid_i;
  logic        addr_last_i;
  logic        addr_ready_o;
  logic [18:0] tag_o;
  logic [8:0]  index_o;
  logic [3:0]  block_offset_o;
  logic        find_start_o;
  logic        updated_i;
  logic        found_in_cache_i;
  logic [19:0] access_count_o;
  logic [19:0] hit_count_o;
  logic        busy_o;
  logic        trace_done_o;
  logic        timeout_err_o;

  logic stub_upd, stub_found, man_upd, man_found;
  assign updated_i        = stub_upd | man_upd;
  assign found_in_cache_i = stub_found | man_found;

  cache_request_sequencer dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .addr_in_i        (addr_in_i),
    .addr_valid_i     (addr_valid_i),
    .addr_last_i      (addr_last_i),
    .addr_ready_o     (addr_ready_o),
    .tag_o            (tag_o),
    .index_o          (index_o),
    .block_offset_o   (block_offset_o),
    .find_start_o     (find_start_o),
    .updated_i        (updated_i),
    .found_in_cache_i (found_in_cache_i),
    .access_count_o   (access_count_o),
    .hit_count_o      (hit_count_o),
    .busy_o           (busy_o),
    .trace_done_o     (trace_done_o),
    .timeout_err_o    (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        found;
    logic        answer;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_access;
  int   exp_hit;
  int   last_fall;
  bit   stall = 1'b0;
  bit   stub_active;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cache stub: checks issued fields in order against the scoreboard and
  // answers each entry as the scoreboard entry dictates.
  initial begin
    exp_t e;
    stub_upd = 1'b0; stub_found = 1'b0; stub_active = 1'b0;
    exp_access = 0; exp_hit = 0; last_fall = -10;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_access = 0;
        exp_hit    = 0;
      end else if (find_start_o) begin
        stub_active = 1'b1;
        check_val("fs_gap", 32'((cyc - last_fall) >= 2), 32'd1);
        if (sb.size() == 0) begin
          check_val("sb_empty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check_val("tag", 32'(tag_o), 32'(e.addr[31:13]));
          check_val("index", 32'(index_o), 32'(e.addr[12:4]));
          check_val("offset", 32'(block_offset_o), 32'(e.addr[3:0]));
          @(negedge clk_i);
          check_val("fs_pulse", 32'(find_start_o), 32'd0);
          if (e.answer) begin
            repeat (e.lat - 1) @(negedge clk_i);
            for (int k = 0; k < 500 && stall; k++) @(negedge clk_i);
            stub_upd   = 1'b1;
            stub_found = e.found;
            exp_access++;
            if (e.found) exp_hit++;
            @(negedge clk_i);
            stub_upd   = 1'b0;
            stub_found = 1'b0;
            last_fall  = cyc;
          end
        end
        stub_active = 1'b0;
      end
    end
  end

  task automatic push_addr(input logic [31:0] a, input logic last, input logic found,
                           input logic answer, input int lat);
    exp_t e;
    bit   done;
    done     = 1'b0;
    e.addr   = a;
    e.found  = found;
    e.answer = answer;
    e.lat    = lat;
    addr_in_i    = a;
    addr_last_i  = last;
    addr_valid_i = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      if (addr_ready_o) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(negedge clk_i);
    end
    addr_valid_i = 1'b0;
    addr_last_i  = 1'b0;
    if (!done) check_val("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (find_start_o) seen = 1'b1;
      else @(negedge clk_i);
    end
    if (!seen) check_val("fs_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      if (!busy_o && sb.size() == 0 && !stub_active) ok = 1'b1;
      else @(negedge clk_i);
    end
    if (!ok) check_val("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_ready"}, 32'(addr_ready_o), 32'd0);
    check_val({pfx, "_tag"}, 32'(tag_o), 32'd0);
    check_val({pfx, "_index"}, 32'(index_o), 32'd0);
    check_val({pfx, "_offset"}, 32'(block_offset_o), 32'd0);
    check_val({pfx, "_fs"}, 32'(find_start_o), 32'd0);
    check_val({pfx, "_access"}, 32'(access_count_o), 32'd0);
    check_val({pfx, "_hit"}, 32'(hit_count_o), 32'd0);
    check_val({pfx, "_busy"}, 32'(busy_o), 32'd0);
    check_val({pfx, "_done"}, 32'(trace_done_o), 32'd0);
    check_val({pfx, "_tmo"}, 32'(timeout_err_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    addr_in_i = '0; addr_valid_i = 1'b0; addr_last_i = 1'b0;
    man_upd = 1'b0; man_found = 1'b0;
    repeat (2) @(negedge clk_i);
    check_all_zero("rst");
    rst_i = 1'b0;
    @(negedge clk_i);
    check_val("ready_after_rst", 32'(addr_ready_o), 32'd1);

    // 1/2: field split, issue latency, hit counted
    push_addr(32'h0001_2345, 1'b0, 1'b1, 1'b1, 3);
    check_val("t1_fs_early", 32'(find_start_o), 32'd0);
    @(negedge clk_i);
    check_val("t1_fs", 32'(find_start_o), 32'd1);
    check_val("t1_tag", 32'(tag_o), 32'h9);
    check_val("t1_index", 32'(index_o), 32'h034);
    check_val("t1_offset", 32'(block_offset_o), 32'h5);
    wait_idle();
    check_val("t2_access", 32'(access_count_o), 32'd1);
    check_val("t2_hit", 32'(hit_count_o), 32'd1);
    check_val("t2_done", 32'(trace_done_o), 32'd0);

    // 3: FIFO fills while the cache is stalled; all entries issued in order
    stall = 1'b1;
    push_addr(32'hA000_0010, 1'b0, 1'b1, 1'b1, 1);
    wait_fs();
    for (int i = 0; i < 8; i++)
      push_addr(32'h1000_0000 + 32'(i * 32'h111), 1'b0, 1'(i % 2), 1'b1, 1);
    check_val("t3_full", 32'(addr_ready_o), 32'd0);
    check_val("t3_busy", 32'(busy_o), 32'd1);
    stall = 1'b0;
    push_addr(32'h2FFF_FFF0, 1'b0, 1'b1, 1'b1, 2);
    wait_idle();
    check_val("t3_access", 32'(access_count_o), 32'(exp_access));
    check_val("t3_hit", 32'(hit_count_o), 32'(exp_hit));
    check_val("t3_access_n", 32'(access_count_o), 32'd11);

    // 4: no answer -> timeout, nothing counted, next entry still issued
    push_addr(32'h3333_3333, 1'b0, 1'b1, 1'b0, 1);
    wait_fs();
    push_addr(32'h4444_4440, 1'b0, 1'b0, 1'b1, 2);
    repeat (63) @(negedge clk_i);
    check_val("t4_tmo_early", 32'(timeout_err_o), 32'd0);
    @(negedge clk_i);
    check_val("t4_tmo", 32'(timeout_err_o), 32'd1);
    check_val("t4_access", 32'(access_count_o), 32'(exp_access));
    wait_idle();
    check_val("t4_next_access", 32'(access_count_o), 32'd12);
    check_val("t4_next_hit", 32'(hit_count_o), 32'(exp_hit));

    // 5: reset in WAIT abandons the access
    push_addr(32'h5555_5550, 1'b0, 1'b1, 1'b0, 1);
    wait_fs();
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 check_all_zero("t5");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    man_upd = 1'b1; man_found = 1'b1;
    @(negedge clk_i);
    man_upd = 1'b0; man_found = 1'b0;
    @(negedge clk_i);
    check_val("t5_access", 32'(access_count_o), 32'd0);
    check_val("t5_hit", 32'(hit_count_o), 32'd0);
    check_val("t5_busy", 32'(busy_o), 32'd0);

    // 6: hit/miss/hit with last flag
    push_addr(32'h0000_1000, 1'b0, 1'b1, 1'b1, 2);
    push_addr(32'h0000_2004, 1'b0, 1'b0, 1'b1, 1);
    push_addr(32'h0000_300C, 1'b1, 1'b1, 1'b1, 3);
    wait_idle();
    check_val("t6_access", 32'(access_count_o), 32'd3);
    check_val("t6_hit", 32'(hit_count_o), 32'd2);
    check_val("t6_done", 32'(trace_done_o), 32'd1);
    check_val("t6_busy", 32'(busy_o), 32'd0);
    check_val("t6_model", 32'(access_count_o), 32'(exp_access));
    push_addr(32'h0000_4000, 1'b0, 1'b0, 1'b1, 1);
    wait_idle();
    check_val("t6_post_access", 32'(access_count_o), 32'd4);
    check_val("t6_post_done", 32'(trace_done_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
